flash_clkrst_ctrl: RTL and testbench
====================================

FLASH_CLKRST_CTRL -- requirements
Module: flash_clkrst_ctrl

Interface
REQ-001 SHALL have port: wb_clk_i  in  1  single block clock.
REQ-002 SHALL have port: wb_rst_i  in  1  asynchronous reset, active-high.
REQ-003 SHALL have port: cfg_div  in  4  flash_clk half-period in wb_clk_i cycles, minus 1.
REQ-004 SHALL have port: cfg_rst_len  in  8  flash reset pulse length, minus 1.
REQ-005 SHALL have port: sw_rst  in  1  one-cycle request to re-run the flash reset sequence.
REQ-006 SHALL have ports: req_mgmt, req_hk  in  1 each  flash ownership requests, held while owning.
REQ-007 SHALL have ports: gnt_mgmt, gnt_hk  out  1 each  ownership grants, at most one high.
REQ-008 SHALL have ports: mgmt_csb, hk_csb, mgmt_clk_en, hk_clk_en  in  1 each  per-requester chip-select and clock enable.
REQ-009 SHALL have ports: mgmt_do, mgmt_oeb, hk_do, hk_oeb  in  4 each  per-requester IO data and output-enable-bar.
REQ-010 SHALL have ports: flash_csb, flash_clk, flash_rstn  out  1 each  flash control towards the pad buffers.
REQ-011 SHALL have ports: flash_do, flash_oeb  out  4 each  muxed IO towards the pad buffers.
REQ-012 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states RST_HOLD, WAKE, IDLE, OWN_MGMT, OWN_HK, HANDOVER.
REQ-014 RST_HOLD SHALL drive flash_rstn=0 for cfg_rst_len+1 cycles, then go to WAKE.
REQ-015 WAKE SHALL drive flash_rstn=1 and hold for 16 cycles, then go to IDLE.
REQ-016 IDLE with one request SHALL grant it on the next cycle (state OWN_x, gnt_x=1).
REQ-017 IDLE with both requests SHALL grant the requester not served last; after reset, mgmt wins.
REQ-018 In OWN_x, flash_csb/do/oeb SHALL equal the owner's inputs combinationally.
REQ-019 When no owner exists, outputs SHALL be forced to flash_csb=1, flash_clk=0, flash_do=0, flash_oeb=4'hF.
REQ-020 In OWN_x with x_clk_en=1, flash_clk SHALL toggle every cfg_div+1 cycles, starting low.
REQ-021 In OWN_x with x_clk_en=0, flash_clk SHALL hold its value; the divider counter SHALL hold.
REQ-022 Deassertion of req_x in OWN_x SHALL drop gnt_x in the same cycle.
REQ-023 Deassertion of req_x in OWN_x SHALL force idle outputs and move to HANDOVER.
REQ-024 The divider counter and flash_clk SHALL be zeroed on entry to OWN_x.
REQ-025 HANDOVER SHALL last exactly 2 cycles with idle outputs, then go to IDLE; new requests SHALL wait.
REQ-026 sw_rst in any state SHALL drop both grants and force idle outputs next cycle.
REQ-027 sw_rst in any state SHALL enter RST_HOLD with a freshly restarted count.
REQ-028 sw_rst SHALL take priority over all simultaneous events.
REQ-029 A cfg_div change SHALL take effect at the next divider reload only.
REQ-030 A cfg_rst_len change SHALL take effect at the next RST_HOLD entry only.
REQ-031 Requests arriving during RST_HOLD or WAKE SHALL be held off; gnt_x SHALL stay 0.

Reset
REQ-032 On wb_rst_i: state=RST_HOLD, counters=0, last-served=hk, gnt_mgmt=0, gnt_hk=0, flash_rstn=0, flash_csb=1, flash_clk=0, flash_do=0, flash_oeb=4'hF, busy=1.
REQ-033 After wb_rst_i deasserts, the RST_HOLD count SHALL begin on the first clock edge.

Structure
REQ-034 The state encoding and the WAKE_CYCLES=16 and HANDOVER_CYCLES=2 constants SHALL live in a shared package, flash_ctrl_pkg.
REQ-035 The clock divider SHALL be a separate sub-module, flash_clk_div (inputs: enable, restart, cfg_div; output: clk level).

Verification
REQ-036 Reset release with cfg_rst_len=3 -> flash_rstn low exactly 4 cycles, then 16 WAKE cycles, then busy=0.
REQ-037 req_mgmt and req_hk raised together in IDLE -> gnt_mgmt first; after mgmt releases and 2 HANDOVER cycles, gnt_hk.
REQ-038 OWN_HK with cfg_div=2 and hk_clk_en=1 -> flash_clk period 6 cycles, first rising edge 3 cycles after grant.
REQ-039 hk_clk_en dropped mid-high phase -> flash_clk stays 1 until re-enabled, then completes the remaining count.
REQ-040 sw_rst during OWN_MGMT with mgmt_csb=0 -> next cycle gnt_mgmt=0, flash_csb=1, flash_oeb=4'hF, flash_rstn=0.
REQ-041 wb_rst_i asserted mid-HANDOVER -> all outputs immediately take their REQ-032 values.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// flash_ctrl_pkg
// Shared definitions for the flash clock/reset controller: controller state
// encoding, requester identifiers, counter widths and sequencing constants.
// ----------------------------------------------------------------------------
package flash_ctrl_pkg;

   localparam int CNT_W           = 8;   // wide enough for cfg_rst_len
   localparam int DIV_W           = 4;   // width of cfg_div
   localparam int WAKE_CYCLES     = 16;
   localparam int HANDOVER_CYCLES = 2;

   // Terminal counts: a phase of N cycles counts 0 .. N-1.
   localparam logic [CNT_W-1:0] WAKE_LAST     = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HANDOVER_LAST = CNT_W'(HANDOVER_CYCLES - 1);

   localparam logic [3:0] OEB_IDLE = 4'hF;

   typedef enum logic [2:0] {
      RST_HOLD,
      WAKE,
      IDLE,
      OWN_MGMT,
      OWN_HK,
      HANDOVER
   } state_t;

   typedef enum logic {
      SRC_MGMT,
      SRC_HK
   } src_t;

endpackage

// File: rtl/flash_clk_div.sv
// ----------------------------------------------------------------------------
// flash_clk_div
// Divider producing the flash_clk level. The level toggles after every
// cfg_div+1 enabled cycles. The divide ratio is sampled only when the count
// reloads (on restart or on a toggle), so a cfg_div change never shortens
// or stretches a half-period already in progress.
//
// Ports
//   clk      block clock
//   rst      asynchronous reset, active-high
//   enable   advance the count this cycle; when low, count and level hold
//   restart  zero count and level, and sample cfg_div
//   cfg_div  half-period in clk cycles, minus 1
//   clk_lvl  divided clock level, starts low
// ----------------------------------------------------------------------------
module flash_clk_div
   import flash_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             restart,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             clk_lvl
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         div_q   <= '0;
         clk_lvl <= 1'b0;
      end else if (restart) begin
         cnt_q   <= '0;
         div_q   <= cfg_div;
         clk_lvl <= 1'b0;
      end else if (enable) begin
         if (cnt_q == div_q) begin
            cnt_q   <= '0;
            div_q   <= cfg_div;
            clk_lvl <= ~clk_lvl;
         end else begin
            cnt_q <= cnt_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/flash_clkrst_ctrl.sv
// ----------------------------------------------------------------------------
// flash_clkrst_ctrl
// Sequences the flash reset (hold, then wake-up delay), arbitrates flash
// ownership between the management (mgmt) and housekeeping (hk) requesters,
// and muxes the owner's chip-select, IO and divided clock to the pads.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   cfg_div                   flash_clk half-period in cycles, minus 1
//   cfg_rst_len               flash reset pulse length in cycles, minus 1
//   sw_rst                    one-cycle request to rerun the reset sequence
//   req_mgmt, req_hk          ownership requests, held while owning
//   gnt_mgmt, gnt_hk          ownership grants (one-hot or zero)
//   mgmt_*/hk_*               per-requester csb, clock enable, IO data, oeb
//   flash_csb/clk/rstn/do/oeb towards the pad buffers
//   busy                      high in every state except IDLE
// ----------------------------------------------------------------------------
module flash_clkrst_ctrl
   import flash_ctrl_pkg::*;
(
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_rst_len,
   input  logic             sw_rst,
   input  logic             req_mgmt,
   input  logic             req_hk,
   output logic             gnt_mgmt,
   output logic             gnt_hk,
   input  logic             mgmt_csb,
   input  logic             hk_csb,
   input  logic             mgmt_clk_en,
   input  logic             hk_clk_en,
   input  logic [3:0]       mgmt_do,
   input  logic [3:0]       mgmt_oeb,
   input  logic [3:0]       hk_do,
   input  logic [3:0]       hk_oeb,
   output logic             flash_csb,
   output logic             flash_clk,
   output logic             flash_rstn,
   output logic [3:0]       flash_do,
   output logic [3:0]       flash_oeb,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   src_t             last_q, last_d;
   logic [CNT_W-1:0] rst_len_q;
   logic [CNT_W-1:0] rst_len_eff;
   logic             fresh_q;
   logic             mgmt_act, hk_act;
   logic             own_state;
   logic             div_en;
   logic             div_lvl;

   // The hold after wb_rst_i uses the length present on the first clock
   // after release; a hold started by sw_rst uses the length sampled with it.
   assign rst_len_eff = fresh_q ? cfg_rst_len : rst_len_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= RST_HOLD;
         cnt_q     <= '0;
         last_q    <= SRC_HK;
         rst_len_q <= '0;
         fresh_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         fresh_q <= 1'b0;
         if (fresh_q || sw_rst) begin
            rst_len_q <= cfg_rst_len;
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (sw_rst) begin
         state_d = RST_HOLD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RST_HOLD: begin
               if (cnt_q == rst_len_eff) begin
                  state_d = WAKE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAKE: begin
               if (cnt_q == WAKE_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            IDLE: begin
               // On contention the requester not served last wins.
               if (req_mgmt && (!req_hk || last_q == SRC_HK)) begin
                  state_d = OWN_MGMT;
                  last_d  = SRC_MGMT;
               end else if (req_hk) begin
                  state_d = OWN_HK;
                  last_d  = SRC_HK;
               end
            end
            OWN_MGMT: begin
               if (!req_mgmt) begin
                  state_d = HANDOVER;
                  cnt_d   = '0;
               end
            end
            OWN_HK: begin
               if (!req_hk) begin
                  state_d = HANDOVER;
                  cnt_d   = '0;
               end
            end
            HANDOVER: begin
               if (cnt_q == HANDOVER_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = RST_HOLD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Ownership is qualified by the live request so a release drops the grant
   // and the pad outputs in the same cycle.
   assign mgmt_act  = (state_q == OWN_MGMT) && req_mgmt;
   assign hk_act    = (state_q == OWN_HK) && req_hk;
   assign own_state = (state_q == OWN_MGMT) || (state_q == OWN_HK);
   assign div_en    = (mgmt_act && mgmt_clk_en) || (hk_act && hk_clk_en);

   assign gnt_mgmt   = mgmt_act;
   assign gnt_hk     = hk_act;
   assign flash_rstn = (state_q != RST_HOLD);
   assign busy       = (state_q != IDLE);
   assign flash_clk  = (mgmt_act || hk_act) && div_lvl;

   always_comb begin
      flash_csb = 1'b1;
      flash_do  = 4'h0;
      flash_oeb = OEB_IDLE;
      if (mgmt_act) begin
         flash_csb = mgmt_csb;
         flash_do  = mgmt_do;
         flash_oeb = mgmt_oeb;
      end else if (hk_act) begin
         flash_csb = hk_csb;
         flash_do  = hk_do;
         flash_oeb = hk_oeb;
      end
   end

   // Held in restart outside the owner states, so the count and level are
   // already zero on the cycle ownership begins.
   flash_clk_div u_clk_div (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .enable  (div_en),
      .restart (!own_state),
      .cfg_div (cfg_div),
      .clk_lvl (div_lvl)
   );

endmodule

// File: tb/tb_flash_clkrst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_flash_clkrst_ctrl
// Scoreboard bench: every committed cycle pushes the expected pad/grant
// vector from a phase-level reference model; a monitor pops and compares it
// on the falling edge. Directed sequences cover reset timing, arbitration,
// divider timing and resets, followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_flash_clkrst_ctrl;

   logic       wb_clk_i;
   logic       wb_rst_i;
   logic [3:0] cfg_div;
   logic [7:0] cfg_rst_len;
   logic       sw_rst;
   logic       req_mgmt, req_hk;
   logic       gnt_mgmt, gnt_hk;
   logic       mgmt_csb, hk_csb, mgmt_clk_en, hk_clk_en;
   logic [3:0] mgmt_do, mgmt_oeb, hk_do, hk_oeb;
   logic       flash_csb, flash_clk, flash_rstn;
   logic [3:0] flash_do, flash_oeb;
   logic       busy;

   flash_clkrst_ctrl dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .cfg_div     (cfg_div),
      .cfg_rst_len (cfg_rst_len),
      .sw_rst      (sw_rst),
      .req_mgmt    (req_mgmt),
      .req_hk      (req_hk),
      .gnt_mgmt    (gnt_mgmt),
      .gnt_hk      (gnt_hk),
      .mgmt_csb    (mgmt_csb),
      .hk_csb      (hk_csb),
      .mgmt_clk_en (mgmt_clk_en),
      .hk_clk_en   (hk_clk_en),
      .mgmt_do     (mgmt_do),
      .mgmt_oeb    (mgmt_oeb),
      .hk_do       (hk_do),
      .hk_oeb      (hk_oeb),
      .flash_csb   (flash_csb),
      .flash_clk   (flash_clk),
      .flash_rstn  (flash_rstn),
      .flash_do    (flash_do),
      .flash_oeb   (flash_oeb),
      .busy        (busy)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct packed {
      logic       gm;
      logic       gh;
      logic       csb;
      logic       clk;
      logic       rstn;
      logic       busy;
      logic [3:0] dq;
      logic [3:0] oeb;
   } outs_t;

   localparam outs_t RESET_OUTS = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF};

   typedef enum {P_RST, P_WAKE, P_IDLE, P_OWN, P_HAND} phase_e;

   // Reference model: phase, cycles left in a timed phase, owner, enabled
   // clock cycles since the grant, divide value captured at the grant.
   phase_e m_phase;
   int     m_left;
   bit     m_owner_hk;
   bit     m_last_hk;
   int     m_en;
   int     m_div;

   outs_t  exp_q[$];
   string  tag_q[$];
   string  cur_tag;
   outs_t  obs;
   int     n_checks;
   int     n_errors;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_outs(string name, outs_t act, outs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got gm=%b gh=%b csb=%b clk=%b rstn=%b busy=%b do=%h oeb=%h, expected gm=%b gh=%b csb=%b clk=%b rstn=%b busy=%b do=%h oeb=%h",
                  name, $time, act.gm, act.gh, act.csb, act.clk, act.rstn, act.busy, act.dq, act.oeb,
                  exp.gm, exp.gh, exp.csb, exp.clk, exp.rstn, exp.busy, exp.dq, exp.oeb);
      end
   endtask

   function automatic outs_t sample();
      outs_t o;
      o.gm   = gnt_mgmt;
      o.gh   = gnt_hk;
      o.csb  = flash_csb;
      o.clk  = flash_clk;
      o.rstn = flash_rstn;
      o.busy = busy;
      o.dq   = flash_do;
      o.oeb  = flash_oeb;
      return o;
   endfunction

   task automatic model_reset();
      m_phase    = P_RST;
      m_left     = int'(cfg_rst_len) + 1;
      m_owner_hk = 1'b0;
      m_last_hk  = 1'b1;
      m_en       = 0;
      m_div      = 0;
   endtask

   function automatic outs_t model_outs();
      outs_t o;
      bit owning;
      owning = (m_phase == P_OWN) && (m_owner_hk ? req_hk : req_mgmt);
      o.gm   = owning && !m_owner_hk;
      o.gh   = owning && m_owner_hk;
      o.csb  = owning ? (m_owner_hk ? hk_csb : mgmt_csb) : 1'b1;
      o.dq   = owning ? (m_owner_hk ? hk_do : mgmt_do) : 4'h0;
      o.oeb  = owning ? (m_owner_hk ? hk_oeb : mgmt_oeb) : 4'hF;
      // Level is the parity of completed half-periods.
      o.clk  = owning && (((m_en / (m_div + 1)) % 2) == 1);
      o.rstn = (m_phase != P_RST);
      o.busy = (m_phase != P_IDLE);
      return o;
   endfunction

   task automatic model_tick();
      if (wb_rst_i) begin
         model_reset();
      end else if (sw_rst) begin
         m_phase = P_RST;
         m_left  = int'(cfg_rst_len) + 1;
      end else begin
         case (m_phase)
            P_RST: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = P_WAKE;
                  m_left  = 16;
               end
            end
            P_WAKE: begin
               m_left--;
               if (m_left == 0) m_phase = P_IDLE;
            end
            P_IDLE: begin
               if (req_mgmt || req_hk) begin
                  m_owner_hk = req_hk && (!req_mgmt || !m_last_hk);
                  m_last_hk  = m_owner_hk;
                  m_phase    = P_OWN;
                  m_en       = 0;
                  m_div      = int'(cfg_div);
               end
            end
            P_OWN: begin
               if (!(m_owner_hk ? req_hk : req_mgmt)) begin
                  m_phase = P_HAND;
                  m_left  = 2;
               end else if (m_owner_hk ? hk_clk_en : mgmt_clk_en) begin
                  m_en++;
               end
            end
            P_HAND: begin
               m_left--;
               if (m_left == 0) m_phase = P_IDLE;
            end
            default: m_phase = P_RST;
         endcase
      end
   endtask

   // Commit the inputs driven for this cycle: push the expectation, advance
   // the model across the coming edge, sample the DUT mid-cycle into obs.
   task automatic step();
      if (wb_rst_i) model_reset();
      exp_q.push_back(model_outs());
      tag_q.push_back(cur_tag);
      model_tick();
      @(negedge wb_clk_i);
      obs = sample();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Monitor: compares whatever expectation is pending at each falling edge.
   initial begin
      outs_t e;
      string t;
      forever begin
         @(negedge wb_clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_outs(t, sample(), e);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int low, wake, gap, first, second, t, held, rem, g, gnt_seen;
      bit prev;
      n_checks = 0;
      n_errors = 0;
      wb_rst_i = 1'b1;  cfg_div = 4'd2;    cfg_rst_len = 8'd3; sw_rst = 1'b0;
      req_mgmt = 1'b0;  req_hk = 1'b0;
      mgmt_csb = 1'b1;  hk_csb = 1'b1;     mgmt_clk_en = 1'b0; hk_clk_en = 1'b0;
      mgmt_do  = 4'h0;  mgmt_oeb = 4'hF;   hk_do = 4'h0;       hk_oeb = 4'hF;
      model_reset();
      @(posedge wb_clk_i);
      #1;

      cur_tag = "reset";
      step();
      step();
      check_outs("reset_state", obs, RESET_OUTS);

      // Reset release: hold length cfg_rst_len+1, then the wake delay.
      cur_tag = "rst_seq";
      wb_rst_i = 1'b0;
      low = 0;
      wake = 0;
      for (int c = 0; c < 300; c++) begin
         step();
         if (!obs.rstn) low++;
         else if (obs.busy) wake++;
         else break;
      end
      check("rstn_low_cycles", low, 4);
      check("wake_cycles", wake, 16);

      // Simultaneous requests after reset: mgmt first, hk after handover.
      cur_tag = "arbitrate";
      req_mgmt = 1'b1; req_hk = 1'b1;
      mgmt_csb = 1'b0; mgmt_do = 4'hA; mgmt_oeb = 4'h0; mgmt_clk_en = 1'b1;
      hk_csb = 1'b0;   hk_do = 4'h5;   hk_oeb = 4'h3;   hk_clk_en = 1'b1;
      step();
      step();
      check("first_grant_mgmt", {obs.gm, obs.gh}, 2);
      repeat (4) begin
         mgmt_do = 4'($urandom);
         step();
      end
      req_mgmt = 1'b0;
      step();
      check("gnt_drop_same_cycle", obs.gm, 0);
      gap = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         gap++;
         if (obs.gh) break;
      end
      check("hk_grant_delay", gap, 4);

      // Divider with cfg_div=2: first rise 3 cycles after grant, period 6.
      cur_tag = "divider";
      t = 0;
      prev = obs.clk;
      first = -1;
      second = -1;
      while (second < 0 && t < 40) begin
         step();
         t++;
         if (obs.clk && !prev) begin
            if (first < 0) first = t;
            else second = t;
         end
         prev = obs.clk;
      end
      check("first_rise", first, 3);
      check("clk_period", second - first, 6);

      // Clock enable dropped one cycle into the high phase: level and count
      // hold, then the last enabled cycle of the phase completes it.
      step();
      hk_clk_en = 1'b0;
      held = 0;
      repeat (5) begin
         step();
         if (obs.clk) held++;
      end
      check("clk_hold_high", held, 5);
      hk_clk_en = 1'b1;
      rem = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!obs.clk) break;
         rem++;
      end
      check("remaining_high", rem, 1);

      // sw_rst while mgmt owns with csb low.
      cur_tag = "sw_reset";
      req_hk = 1'b0;
      step();
      req_mgmt = 1'b1; mgmt_csb = 1'b0; mgmt_oeb = 4'h0; mgmt_do = 4'h6;
      g = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (obs.gm) begin
            g = 1;
            break;
         end
      end
      check("mgmt_regrant", g, 1);
      cfg_rst_len = 8'd1;
      step();
      sw_rst = 1'b1;
      step();
      sw_rst = 1'b0;
      cfg_rst_len = 8'd9;  // must not stretch the hold already started
      step();
      check("swrst_next_cycle", {obs.gm, obs.csb, obs.oeb, obs.rstn}, 7'b0111110);
      low = 1;
      wake = 0;
      gnt_seen = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (obs.gm || obs.gh) gnt_seen = 1;
         if (!obs.rstn) low++;
         else if (obs.busy) wake++;
         else break;
      end
      check("swrst_hold_cycles", low, 2);
      check("swrst_wake_cycles", wake, 16);
      check("no_grant_in_reset", gnt_seen, 0);
      step();
      check("grant_after_wake", obs.gm, 1);

      // wb_rst_i asserted between edges while in HANDOVER.
      cur_tag = "rst_handover";
      req_mgmt = 1'b0;
      step();
      wb_rst_i = 1'b1;
      step();
      check_outs("rst_mid_handover", obs, RESET_OUTS);
      wb_rst_i = 1'b0;
      step();

      // Randomized traffic.
      cur_tag = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) req_mgmt = ~req_mgmt;
         if ($urandom_range(7) == 0) req_hk = ~req_hk;
         mgmt_clk_en = ($urandom_range(3) != 0);
         hk_clk_en   = ($urandom_range(3) != 0);
         mgmt_csb    = 1'($urandom_range(1));
         hk_csb      = 1'($urandom_range(1));
         mgmt_do     = 4'($urandom);
         mgmt_oeb    = 4'($urandom);
         hk_do       = 4'($urandom);
         hk_oeb      = 4'($urandom);
         sw_rst      = ($urandom_range(149) == 0);
         if (m_phase != P_OWN && $urandom_range(3) == 0) cfg_div = 4'($urandom_range(3));
         if ($urandom_range(15) == 0) cfg_rst_len = 8'($urandom_range(7));
         step();
      end
      sw_rst = 1'b0;

      @(negedge wb_clk_i);
      #1;
      check("scoreboard_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
